// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer sequencer.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    ISSUE,
    WAIT_DONE,
    CS_HOLD
  } xfer_state_t;

  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  // Command length (byte count minus one) and the 17-bit remaining count.
  typedef logic [15:0] xfer_len_t;
  typedef logic [16:0] xfer_rem_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Small synchronous FIFO with valid/ready on both sides. Pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module spi_byte_fifo #(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  output logic [Width-1:0]           rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     depth_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push, pop;

  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign depth_o    = wptr_q - rptr_q;
  assign wr_ready_o = ~full_o;
  assign rd_valid_o = ~empty_o;
  assign rd_data_o  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push on full is then accepted.
  assign pop  = rd_ready_i & ~empty_o;
  assign push = wr_valid_i & (~full_o | pop);

  // Pointer update; reset discards contents by re-aligning the pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Transfer sequencer in front of the SPI byte engine: frames a multi-byte
// transfer with chip-select setup/hold gaps, feeds bytes from the TX FIFO
// and stores returned bytes in the RX FIFO, throttling issue so RX never
// overflows.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         FifoDepth     = 8,
  parameter int         CsSetupCycles = 4,
  parameter int         CsHoldCycles  = 4,
  parameter logic [7:0] DummyByte     = DUMMY_BYTE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [15:0] cmd_len_i,
  input  logic        cmd_tx_en_i,
  input  logic        cmd_rx_en_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        cs_no,
  output logic        start_o,
  output logic [7:0]  tx_byte_o,
  input  logic [7:0]  rx_byte_i,
  input  logic        byte_done_i
);

  localparam int         DW        = $clog2(FifoDepth) + 1;
  localparam logic [15:0] SetupInit = 16'(CsSetupCycles - 1);
  localparam logic [15:0] HoldInit  = 16'(CsHoldCycles - 1);

  xfer_state_t state_q;
  logic [15:0] cnt_q;
  xfer_rem_t   rem_q;
  logic        tx_en_q, rx_en_q, abort_q, done_prev_q;
  logic        cs_n_q, start_q, busy_q, done_q;
  logic [7:0]  tx_byte_q;

  logic [7:0]    tx_head;
  logic          tx_rd_valid, tx_pop, tx_full, tx_empty;
  logic [DW-1:0] tx_depth;
  logic          rx_push, rx_wr_ready, rx_full, rx_empty;
  logic [DW-1:0] rx_depth;
  logic          unused_status;

  logic done_evt, abort_pend, byte_avail, rx_room, issue_slot, issue_fire;

  spi_byte_fifo #(.Depth(FifoDepth), .Width(8)) u_tx_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_data_i  (tx_data_i),
    .wr_valid_i (tx_valid_i),
    .wr_ready_o (tx_ready_o),
    .rd_data_o  (tx_head),
    .rd_valid_o (tx_rd_valid),
    .rd_ready_i (tx_pop),
    .full_o     (tx_full),
    .empty_o    (tx_empty),
    .depth_o    (tx_depth)
  );

  spi_byte_fifo #(.Depth(FifoDepth), .Width(8)) u_rx_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_data_i  (rx_byte_i),
    .wr_valid_i (rx_push),
    .wr_ready_o (rx_wr_ready),
    .rd_data_o  (rx_data_o),
    .rd_valid_o (rx_valid_o),
    .rd_ready_i (rx_ready_i),
    .full_o     (rx_full),
    .empty_o    (rx_empty),
    .depth_o    (rx_depth)
  );

  // Status the sequencer does not need (it works from empty/full alone).
  assign unused_status = ^{tx_rd_valid, tx_full, tx_depth, rx_wr_ready, rx_empty, rx_depth};

  // A long engine done pulse counts once: only its rising edge is an event.
  assign done_evt   = byte_done_i & ~done_prev_q;
  // Abort acts in the cycle it arrives as well as later via the sticky flag.
  assign abort_pend = abort_q | cmd_abort_i;
  assign byte_avail = ~tx_empty | ~tx_en_q;
  // The previous byte is already captured by the time we issue, so a single
  // free RX slot is enough room for the next one.
  assign rx_room    = ~rx_full | ~rx_en_q;
  // The last setup cycle doubles as the first issue slot so start_o rises
  // exactly CsSetupCycles after cs_no falls.
  assign issue_slot = (state_q == ISSUE) || ((state_q == CS_SETUP) && (cnt_q == '0));
  assign issue_fire = issue_slot & ~abort_pend & byte_avail & rx_room;
  assign tx_pop     = issue_fire & tx_en_q;
  assign rx_push    = (state_q == WAIT_DONE) & done_evt & rx_en_q;

  assign cs_no       = cs_n_q;
  assign start_o     = start_q;
  assign tx_byte_o   = tx_byte_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cmd_ready_o = ~busy_q;

  // Previous byte_done_i for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) done_prev_q <= 1'b0;
    else       done_prev_q <= byte_done_i;
  end

  // Transfer FSM with registered chip-select, start, byte and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      abort_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      start_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && cmd_abort_i) abort_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (cmd_valid_i) begin
            tx_en_q <= cmd_tx_en_i;
            rx_en_q <= cmd_rx_en_i;
            rem_q   <= {1'b0, cmd_len_i} + 17'd1;
            cnt_q   <= SetupInit;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CS_SETUP;
          end
        end
        CS_SETUP, ISSUE: begin
          if (abort_pend) begin
            cnt_q   <= HoldInit;
            state_q <= CS_HOLD;
          end else if (issue_fire) begin
            tx_byte_q <= tx_en_q ? tx_head : DummyByte;
            start_q   <= 1'b1;
            state_q   <= WAIT_DONE;
          end else if (state_q == CS_SETUP) begin
            if (cnt_q == '0) state_q <= ISSUE;
            else             cnt_q   <= cnt_q - 16'd1;
          end
        end
        WAIT_DONE: begin
          if (done_evt) begin
            start_q <= 1'b0;
            rem_q   <= rem_q - 17'd1;
            if ((rem_q == 17'd1) || abort_pend) begin
              cnt_q   <= HoldInit;
              state_q <= CS_HOLD;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        CS_HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: an engine model echoes the bitwise NOT of each
// issued byte; expected TX/RX bytes are queued when a command is driven and
// compared as the engine sees starts and as RX entries are popped.
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] cmd_len;
  logic        cmd_tx, cmd_rx, cmd_valid, cmd_ready, cmd_abort;
  logic        busy, done, cs_n, start;
  logic [7:0]  tx_byte, rx_byte;
  logic        byte_done;

  spi_xfer_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .cmd_len_i   (cmd_len),
    .cmd_tx_en_i (cmd_tx),
    .cmd_rx_en_i (cmd_rx),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_abort_i (cmd_abort),
    .busy_o      (busy),
    .done_o      (done),
    .cs_no       (cs_n),
    .start_o     (start),
    .tx_byte_o   (tx_byte),
    .rx_byte_i   (rx_byte),
    .byte_done_i (byte_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;
  int cyc = 0, n_done = 0, n_start = 0, cs_bad = 0, last_done_cyc = 0;
  int lat = 3, hold_n = 1;
  logic eng_en = 1'b1;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) n_done <= n_done + 1;
  always @(negedge clk) if (busy && cs_n) cs_bad <= cs_bad + 1;

  // Engine model: answer each start with ~byte after lat cycles.
  initial begin : engine
    logic [7:0] b;
    byte_done = 1'b0;
    rx_byte   = 8'h00;
    forever begin
      @(negedge clk);
      if (start && !rst && eng_en) begin
        n_start++;
        b = tx_byte;
        if (exp_tx.size() != 0) chk("tx_byte", b, exp_tx.pop_front());
        else                    chk("tx_extra", exp_tx.size(), 1);
        repeat (lat) @(negedge clk);
        chk("tx_stable", tx_byte, b);
        rx_byte       = ~b;
        byte_done     = 1'b1;
        last_done_cyc = cyc;
        repeat (hold_n) @(negedge clk);
        byte_done = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic push_tx(input logic [7:0] d);
    int k;
    k = 0;
    while (!tx_ready && k < 300) begin @(negedge clk); k++; end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic txe, input logic rxe);
    cmd_len = len; cmd_tx = txe; cmd_rx = rxe; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cs_after_cmd", cs_n, 0);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("done_seen", done, 1);
    chk("cs_at_done", cs_n, 1);
  endtask

  task automatic pop_rx(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!rx_valid && k < 300) begin @(negedge clk); k++; end
      chk("rx_valid", rx_valid, 1);
      if (exp_rx.size() != 0) chk("rx_data", rx_data, exp_rx.pop_front());
      else                    chk("rx_extra", exp_rx.size(), 1);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int s0, d0, k;
    logic [7:0] v [10];
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    cmd_len = '0; cmd_tx = 1'b0; cmd_rx = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_n, 1);
    chk("rst_start", start, 0);
    chk("rst_txbyte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rxvalid", rx_valid, 0);
    chk("rst_txready", tx_ready, 1);
    chk("rst_cmdready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Three bytes, echo check, setup and hold timing.
    s0 = n_start; d0 = n_done;
    push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h0F);
    exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C); exp_tx.push_back(8'h0F);
    exp_rx.push_back(8'h5A); exp_rx.push_back(8'hC3); exp_rx.push_back(8'hF0);
    send_cmd(16'd2, 1'b1, 1'b1);
    k = 0;
    while (!start && k < 50) begin @(negedge clk); k++; end
    chk("setup_lat", k, 4);
    wait_done(300);
    chk("hold_lat", cyc - last_done_cyc, 5);
    pop_rx(3);
    chk("t1_starts", n_start - s0, 3);
    chk("t1_done_cnt", n_done - d0, 1);

    // Dummy bytes, RX only; a TX byte queued beforehand must survive.
    push_tx(8'h77);
    s0 = n_start; d0 = n_done;
    for (int i = 0; i < 4; i++) begin exp_tx.push_back(8'hFF); exp_rx.push_back(8'h00); end
    send_cmd(16'd3, 1'b0, 1'b1);
    wait_done(300);
    pop_rx(4);
    chk("t2_starts", n_start - s0, 4);
    chk("t2_done_cnt", n_done - d0, 1);

    // Underrun: only 0x77 queued for a two-byte transfer.
    s0 = n_start;
    exp_tx.push_back(8'h77); exp_tx.push_back(8'h12);
    exp_rx.push_back(8'h88); exp_rx.push_back(8'hED);
    send_cmd(16'd1, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    chk("t3_stall_starts", n_start - s0, 1);
    chk("t3_stall_cs", cs_n, 0);
    chk("t3_stall_start", start, 0);
    push_tx(8'h12);
    wait_done(300);
    pop_rx(2);
    chk("t3_starts", n_start - s0, 2);

    // RX throttle: ten bytes with no pops stall after eight.
    s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      v[i] = 8'(i * 29 + 3);
      exp_tx.push_back(v[i]);
      exp_rx.push_back(~v[i]);
    end
    for (int i = 0; i < 8; i++) push_tx(v[i]);
    send_cmd(16'd9, 1'b1, 1'b1);
    k = 0;
    while ((n_start - s0) < 3 && k < 300) begin @(negedge clk); k++; end
    push_tx(v[8]); push_tx(v[9]);
    repeat (60) @(negedge clk);
    chk("t4_throttle", n_start - s0, 8);
    chk("t4_busy", busy, 1);
    pop_rx(2);
    wait_done(300);
    pop_rx(8);
    chk("t4_starts", n_start - s0, 10);

    // Abort while the second of five bytes is in flight.
    lat = 6;
    s0 = n_start; d0 = n_done;
    push_tx(8'hC1); push_tx(8'hC2); push_tx(8'hC3); push_tx(8'hC4); push_tx(8'hC5);
    exp_tx.push_back(8'hC1); exp_tx.push_back(8'hC2);
    exp_rx.push_back(8'h3E); exp_rx.push_back(8'h3D);
    send_cmd(16'd4, 1'b1, 1'b1);
    k = 0;
    while ((n_start - s0) < 2 && k < 300) begin @(negedge clk); k++; end
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    wait_done(300);
    chk("abort_hold_lat", cyc - last_done_cyc, 5);
    pop_rx(2);
    chk("abort_starts", n_start - s0, 2);
    chk("abort_done_cnt", n_done - d0, 1);
    chk("abort_rx_empty", rx_valid, 0);
    lat = 3;

    // Long done pulses each count once; drains the bytes abort left behind.
    hold_n = 4;
    s0 = n_start;
    exp_tx.push_back(8'hC3); exp_tx.push_back(8'hC4); exp_tx.push_back(8'hC5);
    exp_rx.push_back(8'h3C); exp_rx.push_back(8'h3B); exp_rx.push_back(8'h3A);
    send_cmd(16'd2, 1'b1, 1'b1);
    wait_done(400);
    repeat (6) @(negedge clk);
    pop_rx(3);
    chk("held_starts", n_start - s0, 3);
    chk("held_rx_empty", rx_valid, 0);
    hold_n = 1;

    // Asynchronous reset with the second byte in flight.
    s0 = n_start;
    push_tx(8'h55); push_tx(8'h66);
    exp_tx.push_back(8'h55);
    send_cmd(16'd1, 1'b1, 1'b1);
    k = 0;
    while ((n_start - s0) < 1 && k < 300) begin @(negedge clk); k++; end
    eng_en = 1'b0;
    k = 0;
    while (!(rx_valid && start) && k < 300) begin @(negedge clk); k++; end
    chk("rst_pre_rxvalid", rx_valid, 1);
    chk("rst_pre_start", start, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cs", cs_n, 1);
    chk("arst_start", start, 0);
    chk("arst_rxvalid", rx_valid, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    eng_en = 1'b1;
    @(negedge clk);
    chk("post_rst_txready", tx_ready, 1);
    chk("post_rst_cmdready", cmd_ready, 1);

    chk("cs_frame", cs_bad, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
